// File: rtl/dispatch4_8bits_pkg.sv
// Shared constants, buffer entry type and select decode for the 4-way dispatcher.
package dispatch4_8bits_pkg;

  localparam int DATA_W = 8;
  localparam int N_CH   = 4;
  localparam int SEL_W  = 2;

  localparam logic [DATA_W-1:0] DATA_RST = 8'h00;

  // One buffered transfer: destination tag plus payload (10 bits).
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam entry_t ENTRY_RST = '{sel: '0, data: DATA_RST};

  // One-hot decode of a channel select; also used on the merge side.
  function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] one;
    one = {{(N_CH-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/fifo2_10bits.sv
// Two-entry circular buffer of {sel, data} with 1-bit pointers and a 0..2 count.
module fifo2_10bits
  import dispatch4_8bits_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_entry,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  // Pointer, count and storage update; reset discards all buffered entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: the storage is reset too, so a discarded transfer can never
      // resurface on the outputs after reset is released.
      for (int i = 0; i < 2; i++) mem[i] <= ENTRY_RST;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, regardless of statement order.
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/dispatch4_8bits.sv
// Registered dispatcher: buffers up to two tagged results and presents the
// head on one of four zero-gated channels with per-channel valid/ready.
module dispatch4_8bits
  import dispatch4_8bits_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] y3,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready
);

  entry_t            head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] y_arr [N_CH];

  // Acceptance depends on registered fullness only; a same-cycle pop does not
  // open a slot until the next cycle.
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;

  // Only the addressed consumer's ready can retire the head.
  assign pop = |(out_valid & out_ready);

  fifo2_10bits u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry ('{sel: in_sel, data: in_data}),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // Decode the head onto its channel; idle channels drive zero for OR-merging.
  always_comb begin
    // NOTE: every output gets a default before the conditional drive, so no
    // path leaves a value held and no latch is inferred.
    out_valid = '0;
    for (int k = 0; k < N_CH; k++) y_arr[k] = DATA_RST;
    if (!empty) begin
      out_valid = sel_onehot(head.sel);
      for (int k = 0; k < N_CH; k++) begin
        if (out_valid[k]) y_arr[k] = head.data;
      end
    end
  end

  assign y0 = y_arr[0];
  assign y1 = y_arr[1];
  assign y2 = y_arr[2];
  assign y3 = y_arr[3];

endmodule

// File: tb/tb_dispatch4_8bits.sv
// Self-checking bench for dispatch4_8bits: queue-based reference model checked
// on every falling edge, plus directed scenarios with literal expectations.
module tb_dispatch4_8bits;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;

  int checks   = 0;
  int failures = 0;

  dispatch4_8bits dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } ent_t;

  ent_t q[$];

  always @(posedge clk or posedge rst) begin
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (rst) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && out_ready[q[0].sel];
      do_push = in_valid && (q.size() < 2);
      e.sel   = in_sel;
      e.data  = in_data;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Compare process: outputs are meaningful every cycle, including reset.
  always @(negedge clk) begin
    logic [3:0]  exp_valid;
    logic [31:0] exp_y;
    exp_valid = 4'b0000;
    exp_y     = 32'h0;
    if (q.size() > 0) begin
      exp_valid[q[0].sel] = 1'b1;
      exp_y[8*q[0].sel +: 8] = q[0].data;
    end
    check("model_out_valid", {28'h0, out_valid}, {28'h0, exp_valid});
    check("model_y", {y3, y2, y1, y0}, exp_y);
    check("model_in_ready", {31'h0, in_ready}, {31'h0, (!rst && q.size() < 2)});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00);
    out_ready = 4'b1111;
    #2;
    check("rst_valid", {28'h0, out_valid}, 32'h0);
    check("rst_y", {y3, y2, y1, y0}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rel_in_ready", {31'h0, in_ready}, 32'h1);

    // Single dispatch
    drive(1'b1, 2'd2, 8'hA5);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("single_valid", {28'h0, out_valid}, 32'h4);
    check("single_y", {y3, y2, y1, y0}, 32'h00A5_0000);
    step();
    check("single_after_valid", {28'h0, out_valid}, 32'h0);
    check("single_after_y", {y3, y2, y1, y0}, 32'h0);

    // Backpressure fill
    out_ready = 4'b0000;
    drive(1'b1, 2'd1, 8'h11);
    step();
    drive(1'b1, 2'd3, 8'h22);
    step();
    check("bp_full_ready", {31'h0, in_ready}, 32'h0);
    check("bp_head", {y3, y2, y1, y0}, 32'h0000_1100);
    drive(1'b1, 2'd0, 8'h55);
    step();
    check("bp_held_ready", {31'h0, in_ready}, 32'h0);
    check("bp_held_valid", {28'h0, out_valid}, 32'h2);
    drive(1'b0, 2'd0, 8'h00);
    out_ready = 4'b0010;
    step();
    check("bp_pop_ready", {31'h0, in_ready}, 32'h1);
    check("bp_next_valid", {28'h0, out_valid}, 32'h8);
    check("bp_next_y", {y3, y2, y1, y0}, 32'h2200_0000);
    out_ready = 4'b1000;
    step();
    check("bp_drain", {28'h0, out_valid}, 32'h0);

    // Streaming at count=1
    out_ready = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 2'd0, 8'(k));
      step();
      check("stream_y0", {24'h0, y0}, k);
      check("stream_ready", {31'h0, in_ready}, 32'h1);
    end
    drive(1'b0, 2'd0, 8'h00);
    step();
    check("stream_drain", {28'h0, out_valid}, 32'h0);

    // Head-of-line blocking
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 8'h33);
    step();
    drive(1'b1, 2'd2, 8'h44);
    out_ready = 4'b0100;
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("hol_valid", {28'h0, out_valid}, 32'h1);
    check("hol_y", {y3, y2, y1, y0}, 32'h0000_0033);
    step();
    check("hol_still", {y3, y2, y1, y0}, 32'h0000_0033);
    out_ready = 4'b0101;
    step();
    check("hol_next", {y3, y2, y1, y0}, 32'h0044_0000);
    step();
    check("hol_drain", {28'h0, out_valid}, 32'h0);

    // Zero data with wrong-channel ready
    out_ready = 4'b0111;
    drive(1'b1, 2'd3, 8'h00);
    step();
    drive(1'b0, 2'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      check("zero_valid", {28'h0, out_valid}, 32'h8);
      check("zero_y", {y3, y2, y1, y0}, 32'h0);
      step();
    end
    out_ready = 4'b1000;
    step();
    check("zero_pop", {28'h0, out_valid}, 32'h0);

    // Reset mid-operation
    out_ready = 4'b0000;
    drive(1'b1, 2'd1, 8'hAA);
    step();
    drive(1'b1, 2'd2, 8'hBB);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("mid_full", {31'h0, in_ready}, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_valid", {28'h0, out_valid}, 32'h0);
    check("mid_y", {y3, y2, y1, y0}, 32'h0);
    check("mid_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    rst = 1'b0;
    out_ready = 4'b1111;
    #1;
    check("mid_rel_ready", {31'h0, in_ready}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_no_ghost", {28'h0, out_valid}, 32'h0);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom));
      if ($urandom_range(0, 7) == 0) in_data = 8'h00;
      out_ready = 4'($urandom);
      step();
    end
    drive(1'b0, 2'd0, 8'h00);
    out_ready = 4'b1111;
    step();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch4_8bits.md
# dispatch4_8bits

Registered dispatcher that is the receiving end of the four-way merged result bus. It accepts one 8-bit result plus a 2-bit destination tag per transfer, buffers up to two transfers, and presents each on exactly one of four 8-bit output channels with a per-channel valid/ready handshake. Idle channels drive all-zero data, so the outputs can feed an OR-merge stage directly. It sits between the calculator's result path and the four consumers: display, sign, flags and memory.

## Interface
- DATA_W, 8, width of each data channel
- DEPTH, 2, buffer entries (fixed at 2; pointers are 1 bit)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- in_data  in  8  result value to dispatch
- in_sel  in  2  destination channel (0..3)
- in_valid  in  1  in_data/in_sel valid this cycle
- in_ready  out  1  buffer can accept this cycle
- y0, y1, y2, y3  out  8 each  channel data; 8'h00 when that channel is not valid
- out_valid  out  4  bit k = channel k presenting data
- out_ready  in  4  bit k = consumer k takes data this cycle

## Operation
- Storage: 2-entry circular buffer of {sel[1:0], data[7:0]}.
  - wr_ptr and rd_ptr are 1 bit each and wrap 1->0.
  - count is 0..2.
- Push:
  - Occurs when in_valid && in_ready at the clock edge.
  - Writes entry[wr_ptr] and toggles wr_ptr.
- in_ready = (count != 2) && !rst. It is combinational from count.
- A push is not accepted while full, even if a pop happens the same cycle. in_ready rises the cycle after a pop.
- Head presentation, when count > 0:
  - out_valid = one-hot of head.sel.
  - y[head.sel] = head.data.
  - Every other y is 8'h00.
- Empty (count = 0): out_valid = 4'b0000 and all y = 8'h00.
- Pop:
  - Occurs when out_valid[head.sel] && out_ready[head.sel].
  - Toggles rd_ptr.
  - out_ready bits for non-selected channels are ignored.
- Push and pop in the same cycle: count is unchanged and both pointers toggle.
- Data zero value: a valid entry whose data is 8'h00 still asserts out_valid. Consumers qualify on out_valid, never on nonzero data.
- in_sel is captured only with a push. Values on in_data/in_sel while in_valid=0 have no effect.
- Reset:
  - Asserting rst at any time, including mid-transfer, immediately clears count, wr_ptr, rd_ptr and all buffer entries.
  - out_valid goes to 0, all y go to 8'h00, in_ready goes to 0.
  - Buffered entries are discarded.
  - On deassertion, in_ready = 1 in the first cycle.

## Timing
- Input-to-output latency is 1 cycle. A push at edge N is visible on y/out_valid from just after edge N.
- Outputs are a combinational decode of registered head state only. There is no combinational path from in_* or out_ready to y/out_valid.
- in_ready depends only on registered count and rst.
- Throughput:
  - 1 transfer/cycle while the consumer is always ready.
  - With a stalled consumer, 2 pushes are accepted, then in_ready=0 until the head pops.
- Ordering is strict FIFO across all channels. A stalled channel blocks later entries for other channels (no bypass).
- out_valid stays asserted and y stays stable until the pop edge.

## Structure
- Shared package constants:
  - DATA_W=8, N_CH=4, SEL_W=2.
  - Reset data value 8'h00.
  - The one-hot decode of a 2-bit select, which is reused by the merge side.
- Sub-module fifo2_10bits holds the 2-entry buffer, pointers and count, with push/pop/full/empty/head ports.
- The top level contains the select decode, zero-gating of y0..y3 and the handshake logic.

## Test plan
- Reset then single dispatch:
  - rst pulse, then in_data=8'hA5, in_sel=2, in_valid=1 for one cycle, out_ready=4'b1111.
  - Required: next cycle out_valid=4'b0100, y2=8'hA5, y0/y1/y3=8'h00. The cycle after, all zero.
- Backpressure fill:
  - out_ready=0. Push 8'h11 to ch1, then 8'h22 to ch3.
  - Required: in_ready=0 after the second push. A third value is held off.
  - Raise out_ready[1]: 8'h11 pops, in_ready=1 the next cycle, then ch3 presents 8'h22.
- Simultaneous push/pop at count=1:
  - Stream 8'h01..8'h08 to ch0 with out_ready[0]=1.
  - Required: count stays 1, one output per cycle, in order, no gaps.
- Head-of-line blocking:
  - Push 8'h33 to ch0 with out_ready[0]=0, then 8'h44 to ch2 with out_ready[2]=1.
  - Required: 8'h44 is not presented until 8'h33 pops.
- Zero data and wrong-channel ready:
  - Push 8'h00 to ch3 with out_ready=4'b0111.
  - Required: out_valid=4'b1000 held and no pop, until out_ready[3]=1.
- Reset mid-operation:
  - With 2 entries buffered, assert rst asynchronously between edges.
  - Required: out_valid, all y and in_ready go to 0 immediately, and the old entries never reappear after release.
